pipelined_barrel_shifter: RTL and testbench
===========================================

Name: pipelined_barrel_shifter

Overview:
- Parametrised, pipelined barrel shifter/rotator with valid/ready handshakes on both sides.
- Generalises the combinational 8-bit shifter to any power-of-two WIDTH.
- Adds arithmetic shift mode, one pipeline register per shift-amount bit, and a sideband tag carried alongside each operation.
- Sits in the datapath between the operand issue stage and the ALU result mux; sustains one operation per cycle.

Parameters:
- WIDTH, 8, data width; power of two, >= 4.
- SHAMT_W, $clog2(WIDTH), shift-amount width; derived, not to be overridden.
- TAG_W, 4, sideband tag width; tag passes through unchanged with its data.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  input operation present.
- in_ready  output  1  block accepts input this cycle.
- in_data  input  WIDTH  operand.
- in_amt  input  SHAMT_W  shift amount, 0..WIDTH-1.
- in_dir  input  1  0 = left, 1 = right.
- in_mode  input  2  00 logical, 01 arithmetic, 10 rotate, 11 reserved (treated as logical).
- in_tag  input  TAG_W  sideband tag.
- out_valid  output  1  result present.
- out_ready  input  1  downstream accepts result.
- out_data  output  WIDTH  shifted result.
- out_tag  output  TAG_W  tag of the operation in out_data.

Behaviour:
- Pipeline: SHAMT_W stages.
  - Stage k shifts by 2^k when in_amt[k] is set, else passes the value through.
  - Each stage registers data, remaining amount/dir/mode, tag and a valid bit.
  - Latency: exactly SHAMT_W cycles from accept to out_valid when there is no backpressure (3 cycles for WIDTH=8).
- Handshake:
  - Input is accepted when in_valid && in_ready.
  - Output is consumed when out_valid && out_ready.
  - stall = out_valid && !out_ready; in_ready = !stall (combinational).
  - While stalled, all stage registers hold; no bubble collapse.
  - When not stalled, every stage advances. Empty stages carry valid=0.
  - Throughput is 1 operation per cycle with out_ready held high.
- Mode rules:
  - Logical: vacated bits = 0.
  - Arithmetic right: vacated bits = original MSB.
  - Arithmetic left is identical to logical left.
  - Rotate: bits wrap around.
  - Mode 11 is identical to mode 00.
- in_amt = 0: data passes through unchanged, with the same latency.
- out_data and out_tag stay stable while out_valid && !out_ready.
- No combinational path from in_* to out_*.
- Reset (rst_n low, at any time including mid-stream):
  - All stage valid bits clear immediately; out_valid = 0, out_data = 0, out_tag = 0.
  - In-flight operations are discarded.
  - in_ready = 1 from reset onward.
- Inputs presented while in_valid = 0 are ignored; no state changes other than bubble propagation.

Optional Feature:
- Macro: BARREL_CARRY_EN.
- Defined: adds output port out_carry (1 bit), pipelined with the data and reset to 0.
  - Logical/arithmetic shifts: out_carry = the last bit shifted out (left: in_data[WIDTH-amt]; right: in_data[amt-1]).
  - Rotate: out_carry = out_data[0] for left and out_data[WIDTH-1] for right.
  - amt = 0: out_carry = 0.
- Undefined: port and logic are absent; all other behaviour is identical.

Test Plan (WIDTH=8, TAG_W=4):
- Logical left: in 0xB4 (10110100), amt 2, dir 0, mode 00, tag 3 -> 3 cycles later out_data = 11010000, out_tag = 3, out_carry = 0.
- Right shifts on in 0xB4, amt 3, dir 1:
  - mode 00 -> 00010110, carry 1.
  - mode 01 -> 11110110, carry 1.
- Rotate left: in 0xB4, amt 3, dir 0, mode 10 -> 10100101, carry 1. Same operand with amt 0 -> 10110100, carry 0.
- Back-to-back with backpressure:
  - Stream 4 ops with tags 0..3 on consecutive cycles, out_ready held low after the first result.
  - Required: out_valid = 1 with tag 0 held stable; in_ready = 0.
  - After out_ready rises: tags 0,1,2,3 emerge in order, one per cycle, none lost or duplicated.
- Reset mid-stream: assert rst_n = 0 asynchronously with 2 ops in flight -> out_valid = 0 and out_data = 0 immediately; after release, no stale results appear and in_ready = 1.

Source files
------------

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter/rotator: one register stage per shift-amount bit, valid/ready on both sides.
// Optional out_carry port (last bit shifted out) is built when BARREL_CARRY_EN is defined.
module pipelined_barrel_shifter #(
    parameter  int WIDTH   = 8,
    parameter  int TAG_W   = 4,
    localparam int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_amt,
    input  logic               in_dir,
    input  logic [1:0]         in_mode,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [TAG_W-1:0]   out_tag
`ifdef BARREL_CARRY_EN
    ,
    output logic               out_carry
`endif
);

    localparam logic [1:0] MODE_ARITH = 2'b01;
    localparam logic [1:0] MODE_ROT   = 2'b10;

    // Mode 11 and arithmetic-left fall through to the logical paths.
    function automatic logic [WIDTH-1:0] shift_by(
        input logic [WIDTH-1:0] v,
        input int unsigned      s,
        input logic             dir,
        input logic [1:0]       mode
    );
        logic signed [WIDTH-1:0] sv;
        logic        [WIDTH-1:0] r;
        sv = v;
        if (mode == MODE_ROT) begin
            if (dir) r = (v >> s) | (v << (WIDTH - s));
            else     r = (v << s) | (v >> (WIDTH - s));
        end else if (dir) begin
            if (mode == MODE_ARITH) r = sv >>> s;
            else                    r = v >> s;
        end else begin
            r = v << s;
        end
        return r;
    endfunction

`ifdef BARREL_CARRY_EN
    // The bit leaving (or wrapping) at this step; the last active stage wins.
    function automatic logic shifted_out_bit(
        input logic [WIDTH-1:0] v,
        input int unsigned      s,
        input logic             dir
    );
        logic [SHAMT_W-1:0] idx;
        idx = dir ? SHAMT_W'(s - 1) : SHAMT_W'(WIDTH - s);
        return v[idx];
    endfunction
`endif

    logic               stall;

    logic [WIDTH-1:0]   data_q [SHAMT_W];
    logic [WIDTH-1:0]   data_d [SHAMT_W];
    logic [SHAMT_W-1:0] amt_q  [SHAMT_W];
    logic [SHAMT_W-1:0] amt_d  [SHAMT_W];
    logic               dir_q  [SHAMT_W];
    logic               dir_d  [SHAMT_W];
    logic [1:0]         mode_q [SHAMT_W];
    logic [1:0]         mode_d [SHAMT_W];
    logic [TAG_W-1:0]   tag_q  [SHAMT_W];
    logic [TAG_W-1:0]   tag_d  [SHAMT_W];
    logic               vld_q  [SHAMT_W];
    logic               vld_d  [SHAMT_W];
`ifdef BARREL_CARRY_EN
    logic               carry_q [SHAMT_W];
    logic               carry_d [SHAMT_W];
`endif

    assign stall    = vld_q[SHAMT_W-1] && !out_ready;
    assign in_ready = !stall;

    for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
        localparam int unsigned STEP = 1 << k;

        logic [WIDTH-1:0]   src_data;
        logic [SHAMT_W-1:0] src_amt;
        logic               src_dir;
        logic [1:0]         src_mode;
        logic [TAG_W-1:0]   src_tag;
        logic               src_vld;

        if (k == 0) begin : g_src_in
            assign src_data = in_data;
            assign src_amt  = in_amt;
            assign src_dir  = in_dir;
            assign src_mode = in_mode;
            assign src_tag  = in_tag;
            assign src_vld  = in_valid;
        end else begin : g_src_prev
            assign src_data = data_q[k-1];
            assign src_amt  = amt_q[k-1];
            assign src_dir  = dir_q[k-1];
            assign src_mode = mode_q[k-1];
            assign src_tag  = tag_q[k-1];
            assign src_vld  = vld_q[k-1];
        end

        assign data_d[k] = src_amt[k] ? shift_by(src_data, STEP, src_dir, src_mode) : src_data;
        assign amt_d[k]  = src_amt;
        assign dir_d[k]  = src_dir;
        assign mode_d[k] = src_mode;
        assign tag_d[k]  = src_tag;
        assign vld_d[k]  = src_vld;

`ifdef BARREL_CARRY_EN
        logic src_carry;
        if (k == 0) begin : g_carry_in
            assign src_carry = 1'b0;
        end else begin : g_carry_prev
            assign src_carry = carry_q[k-1];
        end
        assign carry_d[k] = src_amt[k] ? shifted_out_bit(src_data, STEP, src_dir) : src_carry;
`endif
    end

    // All stages advance together or hold together; a stall never collapses bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < SHAMT_W; k++) begin
                data_q[k]  <= '0;
                amt_q[k]   <= '0;
                dir_q[k]   <= 1'b0;
                mode_q[k]  <= '0;
                tag_q[k]   <= '0;
                vld_q[k]   <= 1'b0;
`ifdef BARREL_CARRY_EN
                carry_q[k] <= 1'b0;
`endif
            end
        end else if (!stall) begin
            for (int k = 0; k < SHAMT_W; k++) begin
                data_q[k]  <= data_d[k];
                amt_q[k]   <= amt_d[k];
                dir_q[k]   <= dir_d[k];
                mode_q[k]  <= mode_d[k];
                tag_q[k]   <= tag_d[k];
                vld_q[k]   <= vld_d[k];
`ifdef BARREL_CARRY_EN
                carry_q[k] <= carry_d[k];
`endif
            end
        end
    end

    assign out_valid = vld_q[SHAMT_W-1];
    assign out_data  = data_q[SHAMT_W-1];
    assign out_tag   = tag_q[SHAMT_W-1];
`ifdef BARREL_CARRY_EN
    assign out_carry = carry_q[SHAMT_W-1];
`endif

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Self-checking bench for pipelined_barrel_shifter: directed cases, backpressure, mid-stream reset, random traffic.
module tb_pipelined_barrel_shifter;
    localparam int WIDTH   = 8;
    localparam int TAG_W   = 4;
    localparam int SHAMT_W = 3;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_data;
    logic [SHAMT_W-1:0] in_amt;
    logic               in_dir;
    logic [1:0]         in_mode;
    logic [TAG_W-1:0]   in_tag;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_data;
    logic [TAG_W-1:0]   out_tag;
`ifdef BARREL_CARRY_EN
    logic               out_carry;
`endif

    always #5 clk = ~clk;

    pipelined_barrel_shifter #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_amt(in_amt),
        .in_dir(in_dir), .in_mode(in_mode), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag)
`ifdef BARREL_CARRY_EN
        , .out_carry(out_carry)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model in plain integer arithmetic.
    function automatic int ref_data(input int x, input int a, input bit dir, input bit [1:0] mode);
        int p, q2, full;
        p    = 1 << a;
        q2   = 1 << (WIDTH - a);
        full = 1 << WIDTH;
        if (a == 0) return x;
        if (mode == 2'b10) return dir ? (x / p + (x % p) * q2) : ((x * p) % full + x / q2);
        if (!dir) return (x * p) % full;
        if (mode == 2'b01 && x >= full / 2) return x / p + full - q2;
        return x / p;
    endfunction

    function automatic int ref_carry(input int x, input int a, input bit dir);
        if (a == 0) return 0;
        if (!dir) return (x / (1 << (WIDTH - a))) % 2;
        return (x / (1 << (a - 1))) % 2;
    endfunction

    typedef struct {
        int data;
        int tag;
        int carry;
        int acc;
        int st;
    } item_t;

    item_t q[$];
    int    cyc       = 0;
    int    stall_cnt = 0;

    // Every stall cycle delays every in-flight op by one; otherwise an op reaches the output SHAMT_W cycles after acceptance.
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            chk("rst out_valid", out_valid, 0);
            chk("rst out_data", out_data, 0);
            chk("rst out_tag", out_tag, 0);
            chk("rst in_ready", in_ready, 1);
        end else begin
            bit    exp_v;
            int    prog;
            item_t it;
            exp_v = 1'b0;
            prog  = 0;
            if (q.size() > 0) begin
                prog  = cyc - q[0].acc - (stall_cnt - q[0].st);
                exp_v = (prog == SHAMT_W);
                if (prog > SHAMT_W) chk("latency overrun", prog, SHAMT_W);
            end
            chk("out_valid", out_valid, exp_v);
            chk("in_ready", in_ready, !(exp_v && !out_ready));
            if (out_valid && q.size() > 0) begin
                chk("out_data", out_data, q[0].data);
                chk("out_tag", out_tag, q[0].tag);
`ifdef BARREL_CARRY_EN
                chk("out_carry", out_carry, q[0].carry);
`endif
            end
            if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
            if (in_valid && in_ready) begin
                it.data  = ref_data(int'(in_data), int'(in_amt), in_dir, in_mode);
                it.tag   = int'(in_tag);
                it.carry = ref_carry(int'(in_data), int'(in_amt), in_dir);
                it.acc   = cyc;
                it.st    = stall_cnt;
                q.push_back(it);
            end
            if (out_valid && !out_ready) stall_cnt++;
        end
        cyc++;
    end

    task automatic send(input logic [7:0] d, input logic [2:0] a, input logic dir,
                        input logic [1:0] m, input logic [3:0] tg);
        bit ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_amt   = a;
        in_dir   = dir;
        in_mode  = m;
        in_tag   = tg;
        for (int n = 0; n < 64 && !ok; n++) begin
            @(negedge clk);
            ok = in_ready;
        end
        chk("send accepted", ok, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic do_op(input string name, input logic [7:0] d, input logic [2:0] a, input logic dir,
                         input logic [1:0] m, input logic [3:0] tg, input logic [7:0] exp_d, input logic exp_c);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = d;
        in_amt    = a;
        in_dir    = dir;
        in_mode   = m;
        in_tag    = tg;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk({name, " early valid"}, out_valid, 0);
        @(posedge clk);
        #1;
        chk({name, " valid"}, out_valid, 1);
        chk({name, " data"}, out_data, exp_d);
        chk({name, " tag"}, out_tag, tg);
`ifdef BARREL_CARRY_EN
        chk({name, " carry"}, out_carry, exp_c);
`else
        if (exp_c === 1'bx) chk({name, " carry literal"}, exp_c, 0);
`endif
        @(posedge clk);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d", total);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] held;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_amt    = '0;
        in_dir    = 1'b0;
        in_mode   = '0;
        in_tag    = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset out_valid", out_valid, 0);
        chk("reset out_data", out_data, 0);
        chk("reset in_ready", in_ready, 1);
        #1;
        rst_n = 1'b1;

        chk("model lsl2", ref_data(180, 2, 0, 2'b00), 32'hD0);
        chk("model asr3", ref_data(180, 3, 1, 2'b01), 32'hF6);
        chk("model rol3", ref_data(180, 3, 0, 2'b10), 32'hA5);
        chk("model ror2", ref_data(180, 2, 1, 2'b10), 32'h2D);
        chk("model carry rol3", ref_carry(180, 3, 0), 1);

        do_op("lsl2",     8'hB4, 3'd2, 1'b0, 2'b00, 4'd3,  8'hD0, 1'b0);
        do_op("lsr3",     8'hB4, 3'd3, 1'b1, 2'b00, 4'd5,  8'h16, 1'b1);
        do_op("asr3",     8'hB4, 3'd3, 1'b1, 2'b01, 4'd6,  8'hF6, 1'b1);
        do_op("rol3",     8'hB4, 3'd3, 1'b0, 2'b10, 4'd7,  8'hA5, 1'b1);
        do_op("rol0",     8'hB4, 3'd0, 1'b0, 2'b10, 4'd8,  8'hB4, 1'b0);
        do_op("mode11",   8'hB4, 3'd3, 1'b1, 2'b11, 4'd9,  8'h16, 1'b1);
        do_op("asl1",     8'hB4, 3'd1, 1'b0, 2'b01, 4'd10, 8'h68, 1'b1);
        do_op("ror2",     8'hB4, 3'd2, 1'b1, 2'b10, 4'd11, 8'h2D, 1'b0);
        do_op("asr7 pos", 8'h74, 3'd7, 1'b1, 2'b01, 4'd12, 8'h00, 1'b1);
        do_op("asr7 neg", 8'h84, 3'd7, 1'b1, 2'b01, 4'd13, 8'hFF, 1'b0);

        // Backpressure: four back-to-back ops against a stalled output.
        out_ready = 1'b0;
        fork
            begin
                for (int t = 0; t < 4; t++) send(8'(8'h21 * (t + 1)), 3'(t + 1), 1'b0, 2'b10, 4'(t));
            end
            begin
                repeat (8) @(negedge clk);
                held = out_data;
                chk("bp stalled valid", out_valid, 1);
                chk("bp stalled tag", out_tag, 0);
                chk("bp in_ready low", in_ready, 0);
                for (int s = 0; s < 3; s++) begin
                    @(negedge clk);
                    chk("bp data stable", out_data, held);
                    chk("bp tag stable", out_tag, 0);
                    chk("bp in_ready held low", in_ready, 0);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
                for (int t = 0; t < 4; t++) begin
                    @(negedge clk);
                    chk("bp drain valid", out_valid, 1);
                    chk("bp drain tag", out_tag, t);
                end
                @(negedge clk);
                chk("bp no duplicate", out_valid, 0);
            end
        join

        // Reset with two ops in flight, one already at the output.
        repeat (3) @(posedge clk);
        #1;
        send(8'hB4, 3'd2, 1'b0, 2'b00, 4'd5);
        send(8'hB4, 3'd3, 1'b1, 2'b01, 4'd6);
        @(posedge clk);
        #1;
        chk("pre-reset valid", out_valid, 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async rst out_valid", out_valid, 0);
        chk("async rst out_data", out_data, 0);
        chk("async rst out_tag", out_tag, 0);
        chk("async rst in_ready", in_ready, 1);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        for (int s = 0; s < 6; s++) begin
            @(negedge clk);
            chk("post-reset no stale", out_valid, 0);
            chk("post-reset in_ready", in_ready, 1);
        end

        // Random traffic with random backpressure; the compare process checks every cycle.
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = 8'($urandom);
            in_amt    = 3'($urandom);
            in_dir    = 1'($urandom);
            in_mode   = 2'($urandom);
            in_tag    = 4'($urandom);
            out_ready = ((i / 200) % 2 == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("drained queue", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
